// File: rtl/crc_pkg.sv
// ---------------------------------------------------------------------------
// crc_pkg
// Shared definitions for the streaming CRC blocks (checker and generator).
//   state_e           : frame-level FSM states (IDLE / RUN / RESULT)
//   CRC*_POLY         : standard generator polynomials, leading 1 omitted
//   min_beats()       : fewest beats a frame can have and still carry one
//                       payload beat in front of the appended CRC
//   crc_step()        : one DATA_W-bit update of a non-reflected LFSR CRC.
//                       Widths and polynomial are arguments so that any
//                       CRC_W <= 32 / DATA_W <= 64 instance can share it.
// ---------------------------------------------------------------------------
package crc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_RESULT = 2'd2
  } state_e;

  localparam int MAX_CRC_W  = 32;
  localparam int MAX_DATA_W = 64;

  localparam logic [MAX_CRC_W-1:0] CRC8_POLY        = 32'h0000_0007;
  localparam logic [MAX_CRC_W-1:0] CRC16_CCITT_POLY = 32'h0000_1021;
  localparam logic [MAX_CRC_W-1:0] CRC32_POLY       = 32'h04C1_1DB7;

  // ceil(crc_w / data_w) beats hold the CRC itself, plus one payload beat.
  function automatic int min_beats(input int crc_w, input int data_w);
    return (crc_w + data_w - 1) / data_w + 1;
  endfunction

  // Bit-serial update unrolled over data_w bits, data MSB first. The data
  // bit is injected at the MSB feedback tap (standard non-reflected form).
  // Operands are carried at the maximum widths and masked to crc_w; the
  // data word is left-aligned so its first bit is always bit 63, which
  // keeps every bit select constant.
  function automatic logic [MAX_CRC_W-1:0] crc_step(
    input logic [MAX_CRC_W-1:0]  crc,
    input logic [MAX_DATA_W-1:0] data,
    input int                    crc_w,
    input int                    data_w,
    input logic [MAX_CRC_W-1:0]  poly
  );
    logic [MAX_CRC_W-1:0]  c;
    logic [MAX_CRC_W-1:0]  mask;
    logic [MAX_CRC_W-1:0]  msb;
    logic [MAX_DATA_W-1:0] d;
    logic                  fb;
    mask = (crc_w >= MAX_CRC_W) ? '1 : ((32'd1 << crc_w) - 32'd1);
    msb  = 32'd1 << (crc_w - 1);
    c    = crc & mask;
    d    = data << (MAX_DATA_W - data_w);
    for (int i = 0; i < MAX_DATA_W; i++) begin
      if (i < data_w) begin
        fb = ((c & msb) != '0) ^ d[MAX_DATA_W-1];
        c  = ((c << 1) ^ (fb ? poly : '0)) & mask;
        d  = d << 1;
      end
    end
    return c;
  endfunction

endpackage : crc_pkg

// File: rtl/crc_step_unit.sv
// ---------------------------------------------------------------------------
// crc_step_unit
// Purely combinational DATA_W-bit CRC update: crc_o = step(crc_i, data_i).
// Kept separate from the checker FSM so the CRC generator can reuse the
// same arithmetic.
//   crc_i  [CRC_W]  : current CRC register
//   data_i [DATA_W] : beat data, MSB processed first
//   crc_o  [CRC_W]  : CRC register after the whole beat
// ---------------------------------------------------------------------------
module crc_step_unit
  import crc_pkg::*;
#(
  parameter int               CRC_W  = 8,
  parameter logic [CRC_W-1:0] POLY   = CRC_W'(CRC8_POLY),
  parameter int               DATA_W = 8
) (
  input  logic [CRC_W-1:0]  crc_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [CRC_W-1:0]  crc_o
);

  logic [MAX_CRC_W-1:0] crc_full;

  always_comb begin
    crc_full = crc_step(MAX_CRC_W'(crc_i), MAX_DATA_W'(data_i),
                        CRC_W, DATA_W, MAX_CRC_W'(POLY));
  end

  assign crc_o = crc_full[CRC_W-1:0];

endmodule : crc_step_unit

// File: rtl/crc_stream_checker.sv
// ---------------------------------------------------------------------------
// crc_stream_checker
// Receive-side frame checker. Frames arrive as DATA_W-bit beats over a
// valid/ready handshake with the transmitted CRC in the final bits; the
// remainder after the last beat is compared against RESIDUE. Frames with
// fewer than MIN_BEATS beats are flagged as runts and counted as errors.
// Saturating frame and error statistics are kept alongside.
//   clk, rst            : clock, synchronous active-high reset
//   s_valid/s_ready     : beat handshake (s_ready depends on state only)
//   s_data, s_last      : beat data (MSB first), last-beat marker
//   clr_stats           : clears frame_cnt and err_cnt (wins over increment)
//   done                : one-cycle pulse, the cycle after the last beat
//   error, runt         : frame result, valid while done=1
//   frame_len           : beats in the frame (saturating), valid while done=1
//   frame_cnt, err_cnt  : saturating statistics
// ---------------------------------------------------------------------------
module crc_stream_checker
  import crc_pkg::*;
#(
  parameter int               CRC_W   = 8,
  parameter logic [CRC_W-1:0] POLY    = CRC_W'(CRC8_POLY),
  parameter logic [CRC_W-1:0] INIT    = '0,
  parameter logic [CRC_W-1:0] RESIDUE = '0,
  parameter int               DATA_W  = 8,
  parameter int               CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic              clr_stats,
  output logic              done,
  output logic              error,
  output logic              runt,
  output logic [15:0]       frame_len,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int               MIN_BEATS = min_beats(CRC_W, DATA_W);
  localparam logic [15:0]      LEN_MAX   = 16'hFFFF;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_e             state_q;
  logic [CRC_W-1:0]   crc_q;
  logic [15:0]        count_q;
  logic               done_q;
  logic               error_q;
  logic               runt_q;
  logic [15:0]        len_q;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic               accept;
  logic               finish;
  logic [CRC_W-1:0]   crc_base;
  logic [CRC_W-1:0]   crc_d;
  logic [15:0]        count_d;
  logic               runt_d;
  logic               error_d;

  // RESULT is the one-cycle bubble between frames; nothing else stalls.
  assign s_ready = (state_q != ST_RESULT);
  assign accept  = s_valid && s_ready;
  assign finish  = accept && s_last;

  // The first beat of a frame always starts from INIT, independent of
  // whatever crc_q holds, so a frame can never inherit a stale remainder.
  assign crc_base = (state_q == ST_IDLE) ? INIT : crc_q;

  crc_step_unit #(
    .CRC_W  (CRC_W),
    .POLY   (POLY),
    .DATA_W (DATA_W)
  ) u_step (
    .crc_i  (crc_base),
    .data_i (s_data),
    .crc_o  (crc_d)
  );

  // Beat count and frame verdict as they will stand once this beat lands.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    count_d = 16'd1;
    if (state_q != ST_IDLE) begin
      count_d = (count_q == LEN_MAX) ? count_q : count_q + 16'd1;
    end
    runt_d  = (count_d < 16'(MIN_BEATS));
    error_d = (crc_d != RESIDUE) || runt_d;
  end

  // Statistics advance on the edge that accepts s_last, i.e. the same edge
  // that raises done. A coincident clear overrides the increment.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (finish) begin
      if (frame_cnt_q != CNT_MAX) frame_cnt_d = frame_cnt_q + CNT_W'(1);
      if (error_d && (err_cnt_q != CNT_MAX)) err_cnt_d = err_cnt_q + CNT_W'(1);
    end
    if (clr_stats) begin
      frame_cnt_d = '0;
      err_cnt_d   = '0;
    end
  end

  // Frame FSM with registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      crc_q   <= INIT;
      count_q <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      runt_q  <= 1'b0;
      len_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values, independent of statement order.
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE, ST_RUN: begin
          if (accept) begin
            crc_q   <= crc_d;
            count_q <= count_d;
            if (s_last) begin
              state_q <= ST_RESULT;
              done_q  <= 1'b1;
              error_q <= error_d;
              runt_q  <= runt_d;
              len_q   <= count_d;
            end else begin
              state_q <= ST_RUN;
            end
          end
        end
        ST_RESULT: begin
          state_q <= ST_IDLE;
          crc_q   <= INIT;
        end
        default: begin
          state_q <= ST_IDLE;
          crc_q   <= INIT;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign done      = done_q;
  assign error     = error_q;
  assign runt      = runt_q;
  assign frame_len = len_q;
  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule : crc_stream_checker

// File: tb/tb_crc_stream_checker.sv
// ---------------------------------------------------------------------------
// tb_crc_stream_checker
// Three checker instances:
//   group 0 : CRC-8 (0x07), DATA_W=8, CNT_W=16
//   group 1 : CRC-16-CCITT (0x1021), DATA_W=8, CNT_W=16
//   sat     : CRC-8, CNT_W=2, sharing group 0's inputs (counter saturation)
// The reference model computes the remainder by GF(2) long division of
// the whole frame bit string, independent of the LFSR formulation.
// ---------------------------------------------------------------------------
module tb_crc_stream_checker;
  import crc_pkg::*;

  typedef logic [7:0] byte_q_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic        v    [2];
  logic [7:0]  d    [2];
  logic        l    [2];
  logic        clr  [2];
  logic        rdy  [2];
  logic        dn   [2];
  logic        er   [2];
  logic        rn   [2];
  logic [15:0] flen [2];
  logic [15:0] fcnt [2];
  logic [15:0] ecnt [2];

  logic        sat_rdy, sat_dn, sat_er, sat_rn;
  logic [15:0] sat_flen;
  logic [1:0]  sat_fcnt, sat_ecnt;

  int checks   = 0;
  int failures = 0;

  int          cw     [2] = '{8, 16};
  logic [31:0] pl     [2] = '{CRC8_POLY, CRC16_CCITT_POLY};
  int          exp_fc [2] = '{0, 0};
  int          exp_ec [2] = '{0, 0};
  int          exp_sfc = 0;
  int          exp_sec = 0;

  always #5 clk = ~clk;

  crc_stream_checker #(
    .CRC_W(8), .POLY(8'h07), .INIT(8'h00), .RESIDUE(8'h00), .DATA_W(8), .CNT_W(16)
  ) u_dut8 (
    .clk(clk), .rst(rst), .s_valid(v[0]), .s_ready(rdy[0]), .s_data(d[0]),
    .s_last(l[0]), .clr_stats(clr[0]), .done(dn[0]), .error(er[0]), .runt(rn[0]),
    .frame_len(flen[0]), .frame_cnt(fcnt[0]), .err_cnt(ecnt[0])
  );

  crc_stream_checker #(
    .CRC_W(16), .POLY(16'h1021), .INIT(16'h0000), .RESIDUE(16'h0000), .DATA_W(8), .CNT_W(16)
  ) u_dut16 (
    .clk(clk), .rst(rst), .s_valid(v[1]), .s_ready(rdy[1]), .s_data(d[1]),
    .s_last(l[1]), .clr_stats(clr[1]), .done(dn[1]), .error(er[1]), .runt(rn[1]),
    .frame_len(flen[1]), .frame_cnt(fcnt[1]), .err_cnt(ecnt[1])
  );

  crc_stream_checker #(
    .CRC_W(8), .POLY(8'h07), .INIT(8'h00), .RESIDUE(8'h00), .DATA_W(8), .CNT_W(2)
  ) u_dut_sat (
    .clk(clk), .rst(rst), .s_valid(v[0]), .s_ready(sat_rdy), .s_data(d[0]),
    .s_last(l[0]), .clr_stats(clr[0]), .done(sat_dn), .error(sat_er), .runt(sat_rn),
    .frame_len(sat_flen), .frame_cnt(sat_fcnt), .err_cnt(sat_ecnt)
  );

  // Remainder of (INIT * x^n + M(x) * x^w) mod G(x), by long division.
  function automatic logic [31:0] model_crc(input byte_q_t beats, input int w,
                                            input logic [31:0] poly, input logic [31:0] init);
    bit          b[$];
    int          n;
    logic [31:0] r;
    foreach (beats[i]) for (int j = 7; j >= 0; j--) b.push_back(beats[i][j]);
    n = b.size();
    for (int k = 0; k < w; k++) b.push_back(1'b0);
    for (int k = 0; k < w; k++) b[k] ^= init[w-1-k];
    for (int i = 0; i < n; i++) begin
      if (b[i]) begin
        b[i] = 1'b0;
        for (int k = 0; k < w; k++) b[i+1+k] ^= poly[w-1-k];
      end
    end
    r = '0;
    for (int k = 0; k < w; k++) r[w-1-k] = b[n+k];
    return r;
  endfunction

  // Random payload with the correct CRC appended; sometimes one bit of the
  // CRC is flipped so the frame must fail.
  function automatic byte_q_t make_frame(input int g);
    byte_q_t     q;
    int          plen;
    logic [31:0] c;
    plen = $urandom_range(12, 0);
    for (int i = 0; i < plen; i++) q.push_back(8'($urandom));
    c = model_crc(q, cw[g], pl[g], 32'd0);
    for (int k = cw[g] / 8 - 1; k >= 0; k--) q.push_back(8'(c >> (8 * k)));
    if ($urandom_range(3, 0) == 0) q[q.size()-1] ^= 8'(1 << $urandom_range(7, 0));
    return q;
  endfunction

  // Drive one frame on group g and check the RESULT cycle and the cycle after.
  task automatic send(input int g, input byte_q_t beats, input int gap_max,
                      input bit keep_valid, input bit clr_last, input string name);
    int          n;
    int          waits;
    int          gc;
    bit          acc;
    bit          early;
    bit          exp_runt;
    bit          exp_err;
    int          exp_len;
    logic [31:0] rem;
    n        = beats.size();
    rem      = model_crc(beats, cw[g], pl[g], 32'd0);
    exp_runt = (n < (cw[g] + 7) / 8 + 1);
    exp_err  = (rem != 32'd0) || exp_runt;
    exp_len  = (n > 65535) ? 65535 : n;
    early    = 1'b0;
    for (int i = 0; i < n; i++) begin
      gc = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
      repeat (gc) begin
        v[g] = 1'b0; d[g] = 8'($urandom); l[g] = 1'($urandom);
        @(negedge clk);
        if (dn[g]) early = 1'b1;
      end
      v[g] = 1'b1; d[g] = beats[i]; l[g] = (i == n - 1); clr[g] = clr_last && (i == n - 1);
      waits = 0;
      acc   = 1'b0;
      while (!acc) begin
        acc = rdy[g];
        @(negedge clk);
        if (!acc) begin
          waits++;
          if (waits > 8) begin
            checks++; failures++;
            $display("FAIL %s accept_timeout beat=%0d: s_ready stayed %0b, required 1", name, i, rdy[g]);
            v[g] = 1'b0; clr[g] = 1'b0;
            return;
          end
        end
        if ((i != n - 1) && dn[g]) early = 1'b1;
      end
    end
    v[g] = keep_valid; d[g] = 8'($urandom); l[g] = 1'($urandom); clr[g] = 1'b0;

    if (clr_last) begin
      exp_fc[g] = 0; exp_ec[g] = 0;
      if (g == 0) begin exp_sfc = 0; exp_sec = 0; end
    end else begin
      if (exp_fc[g] < 65535) exp_fc[g]++;
      if (exp_err && exp_ec[g] < 65535) exp_ec[g]++;
      if (g == 0) begin
        if (exp_sfc < 3) exp_sfc++;
        if (exp_err && exp_sec < 3) exp_sec++;
      end
    end

    checks++;
    if (early) begin failures++; $display("FAIL %s early_done: done seen before last beat, required none", name); end
    checks++;
    if (dn[g] !== 1'b1) begin failures++; $display("FAIL %s done: got %0b required 1", name, dn[g]); end
    checks++;
    if (rdy[g] !== 1'b0) begin failures++; $display("FAIL %s ready_in_result: got %0b required 0", name, rdy[g]); end
    checks++;
    if (er[g] !== exp_err) begin failures++; $display("FAIL %s error: got %0b required %0b", name, er[g], exp_err); end
    checks++;
    if (rn[g] !== exp_runt) begin failures++; $display("FAIL %s runt: got %0b required %0b", name, rn[g], exp_runt); end
    checks++;
    if (flen[g] !== 16'(exp_len)) begin failures++; $display("FAIL %s frame_len: got %0d required %0d", name, flen[g], exp_len); end
    checks++;
    if (fcnt[g] !== 16'(exp_fc[g])) begin failures++; $display("FAIL %s frame_cnt: got %0d required %0d", name, fcnt[g], exp_fc[g]); end
    checks++;
    if (ecnt[g] !== 16'(exp_ec[g])) begin failures++; $display("FAIL %s err_cnt: got %0d required %0d", name, ecnt[g], exp_ec[g]); end
    if (g == 0) begin
      checks++;
      if (sat_fcnt !== 2'(exp_sfc)) begin failures++; $display("FAIL %s sat_frame_cnt: got %0d required %0d", name, sat_fcnt, exp_sfc); end
      checks++;
      if (sat_ecnt !== 2'(exp_sec)) begin failures++; $display("FAIL %s sat_err_cnt: got %0d required %0d", name, sat_ecnt, exp_sec); end
    end

    @(negedge clk);
    checks++;
    if (dn[g] !== 1'b0) begin failures++; $display("FAIL %s done_pulse: got %0b required 0", name, dn[g]); end
    checks++;
    if (rdy[g] !== 1'b1) begin failures++; $display("FAIL %s ready_after: got %0b required 1", name, rdy[g]); end
  endtask

  function automatic byte_q_t check_string();
    byte_q_t q;
    for (int i = 0; i < 9; i++) q.push_back(8'h31 + 8'(i));
    return q;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    for (int g = 0; g < 2; g++) begin v[g] = 1'b0; d[g] = '0; l[g] = 1'b0; clr[g] = 1'b0; end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (rdy[g] !== 1'b1) begin failures++; $display("FAIL reset_ready g%0d: got %0b required 1", g, rdy[g]); end
      checks++;
      if ({dn[g], er[g], rn[g]} !== 3'b000) begin failures++; $display("FAIL reset_flags g%0d: got %b required 000", g, {dn[g], er[g], rn[g]}); end
      checks++;
      if (flen[g] !== 16'd0) begin failures++; $display("FAIL reset_len g%0d: got %0d required 0", g, flen[g]); end
      checks++;
      if ({fcnt[g], ecnt[g]} !== 32'd0) begin failures++; $display("FAIL reset_cnt g%0d: got %0d/%0d required 0/0", g, fcnt[g], ecnt[g]); end
    end
    checks++;
    if ({sat_fcnt, sat_ecnt} !== 4'd0) begin failures++; $display("FAIL reset_sat_cnt: got %0d/%0d required 0/0", sat_fcnt, sat_ecnt); end
  endtask

  task automatic test_crc8_vector();
    byte_q_t q = check_string();
    q.push_back(8'hF4);
    send(0, q, 0, 1'b0, 1'b0, "crc8_vector");
  endtask

  task automatic test_corrupt();
    byte_q_t q = check_string();
    q.push_back(8'hF4);
    q[2] = 8'h30;
    send(0, q, 0, 1'b0, 1'b0, "crc8_payload_err");
    q = check_string();
    q.push_back(8'hF4 ^ 8'(1 << $urandom_range(7, 0)));
    send(0, q, 0, 1'b0, 1'b0, "crc8_crc_bitflip");
  endtask

  task automatic test_runt();
    byte_q_t q;
    q.push_back(8'h00);
    send(0, q, 0, 1'b0, 1'b0, "crc8_runt");
  endtask

  task automatic test_crc16_vector();
    byte_q_t q = check_string();
    q.push_back(8'h31);
    q.push_back(8'hC3);
    send(1, q, 0, 1'b0, 1'b0, "crc16_vector");
  endtask

  task automatic test_random_gaps();
    for (int k = 0; k < 12; k++) begin
      send(0, make_frame(0), 3, (k != 11) && 1'($urandom), 1'b0, "rand_crc8");
    end
    for (int k = 0; k < 12; k++) begin
      send(1, make_frame(1), 3, (k != 11) && 1'($urandom), 1'b0, "rand_crc16");
    end
  endtask

  task automatic test_back_to_back();
    longint t0;
    longint t1;
    byte_q_t q;
    t0 = longint'($time);
    for (int k = 0; k < 6; k++) begin
      q = {};
      q.push_back(8'($urandom));
      send(0, q, 0, k != 5, 1'b0, "b2b_single");
    end
    t1 = longint'($time);
    checks++;
    if (t1 - t0 != 64'd120) begin failures++; $display("FAIL b2b_period: 6 frames took %0d ns, required 120", t1 - t0); end
  endtask

  task automatic test_reset_mid_frame();
    byte_q_t q;
    bit      seen;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      v[0] = 1'b1; d[0] = 8'($urandom); l[0] = 1'b0;
      @(negedge clk);
    end
    rst = 1'b1;
    l[0] = 1'b1;
    repeat (2) begin @(negedge clk); if (dn[0]) seen = 1'b1; end
    rst = 1'b0; v[0] = 1'b0; l[0] = 1'b0;
    exp_fc = '{0, 0}; exp_ec = '{0, 0}; exp_sfc = 0; exp_sec = 0;
    repeat (2) begin @(negedge clk); if (dn[0]) seen = 1'b1; end
    checks++;
    if (seen) begin failures++; $display("FAIL rst_mid_frame_done: done seen, required none"); end
    checks++;
    if ({fcnt[0], ecnt[0], fcnt[1]} !== 48'd0) begin
      failures++; $display("FAIL rst_mid_frame_cnt: got %0d/%0d/%0d required 0/0/0", fcnt[0], ecnt[0], fcnt[1]);
    end
    q = check_string();
    q.push_back(8'hF4);
    send(0, q, 1, 1'b0, 1'b0, "after_rst_clean");
  endtask

  task automatic test_clr_stats();
    byte_q_t q;
    send(0, make_frame(0), 0, 1'b0, 1'b0, "pre_clr");
    q.push_back(8'h00);
    send(0, q, 0, 1'b0, 1'b1, "clr_with_done_err");
    send(0, make_frame(0), 0, 1'b0, 1'b0, "post_clr");
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    exp_fc[0] = 0; exp_ec[0] = 0; exp_sfc = 0; exp_sec = 0;
    checks++;
    if ({fcnt[0], ecnt[0], sat_fcnt, sat_ecnt} !== 36'd0) begin
      failures++; $display("FAIL idle_clr: got %0d/%0d/%0d/%0d required 0", fcnt[0], ecnt[0], sat_fcnt, sat_ecnt);
    end
  endtask

  task automatic test_saturation();
    byte_q_t q;
    for (int k = 0; k < 5; k++) begin
      q = {};
      q.push_back(8'($urandom));
      send(0, q, 1, 1'b0, 1'b0, "sat_frames");
    end
    checks++;
    if (sat_fcnt !== 2'd3) begin failures++; $display("FAIL sat_frame_cnt_final: got %0d required 3", sat_fcnt); end
    checks++;
    if (fcnt[0] !== 16'd5) begin failures++; $display("FAIL wide_frame_cnt_final: got %0d required 5", fcnt[0]); end
  endtask

  initial begin
    test_reset();
    test_crc8_vector();
    test_corrupt();
    test_runt();
    test_crc16_vector();
    test_random_gaps();
    test_back_to_back();
    test_reset_mid_frame();
    test_clr_stats();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_crc_stream_checker

// File: doc/crc_stream_checker.md
# crc_stream_checker

Parametrised streaming CRC checker, successor to the fixed CRC-8 byte checker. It accepts a frame of DATA_W-bit beats over a valid/ready handshake, with the transmitted CRC appended as the final bits of the frame. One beat is processed per cycle through an unrolled bit-serial update, and the final remainder is compared against a programmable residue. It sits on the receive side of the link datapath and also keeps saturating frame and error statistics.

## Interface
- CRC_W, 8: CRC width in bits, 4..32
- POLY, 8'h07: generator polynomial without the leading 1, CRC_W bits
- INIT, 0: CRC register value at the start of each frame
- RESIDUE, 0: expected remainder after the appended CRC has been processed
- DATA_W, 8: beat width in bits, 8..64
- CNT_W, 16: width of the statistics counters
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- s_valid  in  1  beat valid
- s_ready  out  1  checker can accept a beat
- s_data  in  DATA_W  beat data; MSB is processed first
- s_last  in  1  final beat of the frame, which contains the tail of the CRC
- clr_stats  in  1  clears both statistics counters
- done  out  1  one-cycle pulse: frame result valid
- error  out  1  frame failed; valid only while done=1
- runt  out  1  frame had too few beats; valid only while done=1
- frame_len  out  16  beats in the frame, saturating; valid only while done=1
- frame_cnt  out  CNT_W  frames checked, saturating
- err_cnt  out  CNT_W  failed frames, saturating

## Operation
- A beat is accepted on a rising edge where s_valid && s_ready.
- step(c, d) applies DATA_W iterations, d[DATA_W-1] first:
  - fb = c[CRC_W-1] ^ bit
  - c = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : 0)
  - This is the standard non-reflected LFSR form, with the data bit injected at the MSB feedback.
- States:
  - IDLE: s_ready=1, crc holds INIT.
    - On accept: crc <= step(INIT, s_data), beat count <= 1.
    - If s_last, go to RESULT; otherwise go to RUN.
  - RUN: s_ready=1.
    - On accept: crc <= step(crc, s_data), beat count increments.
    - If s_last, go to RESULT.
  - RESULT: s_ready=0 and done=1 for exactly one cycle, then go to IDLE. crc is reloaded with INIT.
- MIN_BEATS = ceil(CRC_W/DATA_W) + 1, i.e. at least one payload beat.
- runt = (beat count < MIN_BEATS).
- error = (final crc != RESIDUE) || runt.
- The beat count saturates at 16'hFFFF; frame_len reports it.
- frame_cnt increments on every done. err_cnt increments on every done with error=1. Both saturate at all-ones.
- clr_stats clears both counters on the next edge. If it coincides with an increment, the clear wins and the counter reads 0.
- s_valid while s_ready=0 is ignored; upstream holds the beat.
- s_data and s_last are don't-care when s_valid=0. The checker never drops or duplicates an accepted beat.

## Timing
- Reset: state=IDLE, crc=INIT, count=0, done=0, error=0, runt=0, frame_len=0, frame_cnt=0, err_cnt=0. s_ready=1 from the first cycle after reset.
- done, error, runt and frame_len are registered. They are set on the edge that accepts the s_last beat, so they are visible in the following cycle (RESULT), one cycle after the last beat.
- One bubble per frame: the next frame's first beat can be accepted in the cycle after RESULT.
- Back-to-back single-beat frames complete every 2 cycles.
- Reset asserted mid-frame discards the frame. No done is issued and the counters clear.
- frame_cnt and err_cnt update on the same edge that makes done visible.
- s_ready is a pure function of state, with no combinational path from s_valid.

## Structure
- Shared package crc_pkg holds:
  - state enum (IDLE/RUN/RESULT)
  - the crc_step function, parametrised by width and poly
  - MIN_BEATS computation
  - standard polynomial constants: CRC8 0x07, CRC16_CCITT 0x1021, CRC32 0x04C11DB7
- Sub-module: crc_step_unit, a combinational unrolled DATA_W-bit update.
  - Isolates the arithmetic so the generator block can reuse it.
- Counters and the FSM stay in crc_stream_checker.

## Test plan
- CRC_W=8, POLY=07, DATA_W=8, beats "123456789" (0x31..0x39) followed by 0xF4 with s_last -> done one cycle later, error=0, runt=0, frame_len=10, frame_cnt=1.
- Same frame with beat 3 changed to 0x30 -> error=1, runt=0, err_cnt=1. A single bit flip in the CRC beat also gives error=1.
- Single-beat frame 0x00 with s_last -> runt=1, error=1 even though the residue is 0. MIN_BEATS=2.
- CRC_W=16, POLY=1021, DATA_W=8, "123456789" followed by 0x31, 0xC3 -> error=0, frame_len=11.
- Random s_valid gaps, and s_valid held high through RESULT -> no beat is accepted in RESULT, result matches the gap-free run, and s_ready is low only in RESULT.
- Edge cases:
  - rst mid-frame -> no done; the next frame checks clean.
  - clr_stats coincident with done -> counters read 0.
  - CNT_W=2 with 5 frames -> frame_cnt saturates at 3.
